// File: rtl/lsu_arbiter_if.sv
// lsu_arbiter_if: bundles both master request ports and the LSU pin bus of lsu_arbiter
interface lsu_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [15:0] m0_a;
    logic [7:0]  m0_d;
    logic        m0_ack;
    logic        m0_err;
    logic [7:0]  m0_q;
    logic        m1_req;
    logic        m1_we;
    logic [15:0] m1_a;
    logic [7:0]  m1_d;
    logic        m1_ack;
    logic        m1_err;
    logic [7:0]  m1_q;
    logic [15:0] lsu_a;
    logic [7:0]  lsu_d;
    logic        lsu_re;
    logic        lsu_we;
    logic [7:0]  lsu_q;
    logic        busy;
    logic        last_gnt;

    modport slave (
        input  m0_req, m0_we, m0_a, m0_d, m1_req, m1_we, m1_a, m1_d, lsu_q,
        output m0_ack, m0_err, m0_q, m1_ack, m1_err, m1_q,
        output lsu_a, lsu_d, lsu_re, lsu_we, busy, last_gnt
    );

    modport master (
        output m0_req, m0_we, m0_a, m0_d, m1_req, m1_we, m1_a, m1_d, lsu_q,
        input  m0_ack, m0_err, m0_q, m1_ack, m1_err, m1_q,
        input  lsu_a, lsu_d, lsu_re, lsu_we, busy, last_gnt
    );
endinterface

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin two-master sequencer driving a single-ported LSU, one transaction at a time
module lsu_arbiter #(
    parameter int          READ_LAT = 0,
    parameter logic [15:0] ROM_BASE = 16'h8000
) (
    input logic         clk,
    input logic         rst,
    lsu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] WAIT_INIT = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

    state_t      state_q;
    logic        gnt_q;
    logic        wr_q;
    logic        err_q;
    logic [1:0]  cnt_q;
    logic [15:0] lsu_a_q;
    logic [7:0]  lsu_d_q;
    logic        lsu_re_q;
    logic        lsu_we_q;
    logic        busy_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic        m0_err_q;
    logic        m1_err_q;
    logic [7:0]  m0_q_q;
    logic [7:0]  m1_q_q;

    logic        any_req_d;
    logic        win_d;
    logic        win_we_d;
    logic [15:0] win_a_d;
    logic [7:0]  win_dat_d;
    logic        rom_hit_d;
    logic        fin_d;
    logic        cap_d;

    // Winner selection (contention goes to the port not granted last) and transaction-end detection.
    always_comb begin
        any_req_d = bus.m0_req | bus.m1_req;
        win_d     = (bus.m0_req & bus.m1_req) ? ~gnt_q : bus.m1_req;
        win_we_d  = win_d ? bus.m1_we : bus.m0_we;
        win_a_d   = win_d ? bus.m1_a : bus.m0_a;
        win_dat_d = win_d ? bus.m1_d : bus.m0_d;
        rom_hit_d = win_a_d >= ROM_BASE;
        fin_d     = (state_q == ISSUE && (wr_q || READ_LAT == 0)) || (state_q == WAIT && cnt_q == 2'd0);
        cap_d     = fin_d & ~wr_q;
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b1;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 2'd0;
            lsu_a_q  <= 16'd0;
            lsu_d_q  <= 8'd0;
            lsu_re_q <= 1'b0;
            lsu_we_q <= 1'b0;
            busy_q   <= 1'b0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            m0_q_q   <= 8'd0;
            m1_q_q   <= 8'd0;
        end else begin
            m0_ack_q <= fin_d & ~gnt_q;
            m1_ack_q <= fin_d & gnt_q;
            m0_err_q <= fin_d & ~gnt_q & err_q;
            m1_err_q <= fin_d & gnt_q & err_q;
            if (cap_d && !gnt_q) m0_q_q <= bus.lsu_q;
            if (cap_d && gnt_q) m1_q_q <= bus.lsu_q;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        state_q  <= ISSUE;
                        busy_q   <= 1'b1;
                        gnt_q    <= win_d;
                        wr_q     <= win_we_d;
                        err_q    <= win_we_d & rom_hit_d;
                        lsu_a_q  <= win_a_d;
                        lsu_d_q  <= win_dat_d;
                        lsu_re_q <= ~win_we_d;
                        lsu_we_q <= win_we_d & ~rom_hit_d;
                    end
                end
                ISSUE: begin
                    lsu_we_q <= 1'b0;
                    if (fin_d) begin
                        state_q  <= DONE;
                        lsu_re_q <= 1'b0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (fin_d) begin
                        state_q  <= DONE;
                        lsu_re_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lsu_a    = lsu_a_q;
    assign bus.lsu_d    = lsu_d_q;
    assign bus.lsu_re   = lsu_re_q;
    assign bus.lsu_we   = lsu_we_q;
    assign bus.busy     = busy_q;
    assign bus.last_gnt = gnt_q;
    assign bus.m0_ack   = m0_ack_q;
    assign bus.m1_ack   = m1_ack_q;
    assign bus.m0_err   = m0_err_q;
    assign bus.m1_err   = m1_err_q;
    assign bus.m0_q     = m0_q_q;
    assign bus.m1_q     = m1_q_q;
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed checks of lsu_arbiter with zero-latency and two-cycle-latency LSU models
module tb_lsu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lsu_arbiter_if ifa ();
    lsu_arbiter_if ifb ();

    lsu_arbiter #(.READ_LAT(0), .ROM_BASE(16'h8000)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    lsu_arbiter #(.READ_LAT(2), .ROM_BASE(16'h8000)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    // LSU models: RAM below 16'h8000, fixed ROM pattern (a[7:0]^A5) at and above it.
    logic [7:0] mem_a [0:32767];
    logic [7:0] mem_b [0:32767];
    logic [7:0] pb1, pb2;

    always @(posedge clk) begin
        if (ifa.lsu_we && !ifa.lsu_a[15]) mem_a[ifa.lsu_a[14:0]] <= ifa.lsu_d;
        if (ifb.lsu_we && !ifb.lsu_a[15]) mem_b[ifb.lsu_a[14:0]] <= ifb.lsu_d;
        pb1 <= ifb.lsu_a[15] ? (ifb.lsu_a[7:0] ^ 8'hA5) : mem_b[ifb.lsu_a[14:0]];
        pb2 <= pb1;
    end

    assign ifa.lsu_q = ifa.lsu_a[15] ? (ifa.lsu_a[7:0] ^ 8'hA5) : mem_a[ifa.lsu_a[14:0]];
    assign ifb.lsu_q = pb2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", ifa.busy); end
        checks++; if (ifa.last_gnt !== 1'b1) begin errors++; $display("FAIL rst_last_gnt got %b exp 1", ifa.last_gnt); end
        checks++; if ({ifa.lsu_re, ifa.lsu_we, ifa.m0_ack, ifa.m1_ack, ifa.m0_err, ifa.m1_err} !== 6'b0) begin errors++; $display("FAIL rst_ctl got %b exp 000000", {ifa.lsu_re, ifa.lsu_we, ifa.m0_ack, ifa.m1_ack, ifa.m0_err, ifa.m1_err}); end
        checks++; if ({ifa.lsu_a, ifa.lsu_d, ifa.m0_q, ifa.m1_q} !== 40'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {ifa.lsu_a, ifa.lsu_d, ifa.m0_q, ifa.m1_q}); end
        checks++; if (ifb.last_gnt !== 1'b1 || ifb.busy !== 1'b0) begin errors++; $display("FAIL rst_b got gnt=%b busy=%b exp 1/0", ifb.last_gnt, ifb.busy); end
        rst = 1'b1;
    endtask

    task automatic test_write();
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b1; ifa.m0_a = 16'd0; ifa.m0_d = 8'd100;
        tick();
        checks++; if (ifa.lsu_we !== 1'b1 || ifa.lsu_re !== 1'b0) begin errors++; $display("FAIL wr_issue_en got we=%b re=%b exp 1/0", ifa.lsu_we, ifa.lsu_re); end
        checks++; if (ifa.lsu_a !== 16'd0 || ifa.lsu_d !== 8'd100) begin errors++; $display("FAIL wr_issue_bus got a=%h d=%0d exp 0/100", ifa.lsu_a, ifa.lsu_d); end
        checks++; if (ifa.last_gnt !== 1'b0 || ifa.busy !== 1'b1) begin errors++; $display("FAIL wr_gnt got gnt=%b busy=%b exp 0/1", ifa.last_gnt, ifa.busy); end
        checks++; if (ifa.m0_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %b exp 0", ifa.m0_ack); end
        tick();
        checks++; if (ifa.m0_ack !== 1'b1 || ifa.m0_err !== 1'b0 || ifa.m1_ack !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%b err=%b m1ack=%b exp 1/0/0", ifa.m0_ack, ifa.m0_err, ifa.m1_ack); end
        checks++; if (ifa.lsu_we !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got we=%b exp 0", ifa.lsu_we); end
        ifa.m0_req = 1'b0;
        tick();
        checks++; if (ifa.m0_ack !== 1'b0 || ifa.busy !== 1'b0) begin errors++; $display("FAIL wr_idle got ack=%b busy=%b exp 0/0", ifa.m0_ack, ifa.busy); end
    endtask

    task automatic test_read();
        ifa.m1_req = 1'b1; ifa.m1_we = 1'b0; ifa.m1_a = 16'd0; ifa.m1_d = 8'd0;
        tick();
        checks++; if (ifa.lsu_re !== 1'b1 || ifa.lsu_we !== 1'b0 || ifa.lsu_a !== 16'd0) begin errors++; $display("FAIL rd_issue got re=%b we=%b a=%h exp 1/0/0", ifa.lsu_re, ifa.lsu_we, ifa.lsu_a); end
        checks++; if (ifa.last_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", ifa.last_gnt); end
        tick();
        checks++; if (ifa.m1_ack !== 1'b1 || ifa.m0_ack !== 1'b0 || ifa.lsu_re !== 1'b0) begin errors++; $display("FAIL rd_ack got m1=%b m0=%b re=%b exp 1/0/0", ifa.m1_ack, ifa.m0_ack, ifa.lsu_re); end
        checks++; if (ifa.m1_q !== 8'd100 || ifa.m0_q !== 8'd0) begin errors++; $display("FAIL rd_data got m1q=%0d m0q=%0d exp 100/0", ifa.m1_q, ifa.m0_q); end
        ifa.m1_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b0; ifa.m0_a = 16'd0;
        ifa.m1_req = 1'b1; ifa.m1_we = 1'b0; ifa.m1_a = 16'd0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (ifa.m0_ack !== (k == 2 || k == 8)) begin errors++; $display("FAIL rr_m0_ack cycle %0d got %b", k, ifa.m0_ack); end
            checks++; if (ifa.m1_ack !== (k == 5 || k == 11)) begin errors++; $display("FAIL rr_m1_ack cycle %0d got %b", k, ifa.m1_ack); end
            checks++; if (ifa.busy !== (k % 3 != 0)) begin errors++; $display("FAIL rr_busy cycle %0d got %b exp %b", k, ifa.busy, (k % 3 != 0)); end
            if (k % 3 == 1) begin
                checks++; if (ifa.last_gnt !== 1'((k / 3) % 2)) begin errors++; $display("FAIL rr_gnt cycle %0d got %b exp %0d", k, ifa.last_gnt, (k / 3) % 2); end
            end
        end
        ifa.m0_req = 1'b0; ifa.m1_req = 1'b0;
        checks++; if (ifa.m0_q !== 8'd100 || ifa.m1_q !== 8'd100) begin errors++; $display("FAIL rr_data got %0d/%0d exp 100/100", ifa.m0_q, ifa.m1_q); end
        tick();
    endtask

    task automatic test_rom();
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b1; ifa.m0_a = 16'h8000; ifa.m0_d = 8'd48;
        tick();
        checks++; if (ifa.lsu_we !== 1'b0 || ifa.lsu_re !== 1'b0 || ifa.busy !== 1'b1) begin errors++; $display("FAIL rom_issue got we=%b re=%b busy=%b exp 0/0/1", ifa.lsu_we, ifa.lsu_re, ifa.busy); end
        tick();
        checks++; if (ifa.m0_ack !== 1'b1 || ifa.m0_err !== 1'b1 || ifa.lsu_we !== 1'b0) begin errors++; $display("FAIL rom_ack got ack=%b err=%b we=%b exp 1/1/0", ifa.m0_ack, ifa.m0_err, ifa.lsu_we); end
        ifa.m0_we = 1'b0;
        tick();
        checks++; if (ifa.m0_ack !== 1'b0 || ifa.m0_err !== 1'b0) begin errors++; $display("FAIL rom_idle got ack=%b err=%b exp 0/0", ifa.m0_ack, ifa.m0_err); end
        tick();
        checks++; if (ifa.lsu_re !== 1'b1 || ifa.lsu_a !== 16'h8000) begin errors++; $display("FAIL rom_rd_issue got re=%b a=%h exp 1/8000", ifa.lsu_re, ifa.lsu_a); end
        tick();
        checks++; if (ifa.m0_ack !== 1'b1 || ifa.m0_err !== 1'b0 || ifa.m0_q !== 8'hA5) begin errors++; $display("FAIL rom_rd_ack got ack=%b err=%b q=%h exp 1/0/a5", ifa.m0_ack, ifa.m0_err, ifa.m0_q); end
        ifa.m0_req = 1'b0;
        tick();
    endtask

    task automatic test_read_latency();
        ifb.m0_req = 1'b1; ifb.m0_we = 1'b1; ifb.m0_a = 16'd30; ifb.m0_d = 8'd48;
        tick();
        checks++; if (ifb.lsu_we !== 1'b1 || ifb.lsu_a !== 16'd30 || ifb.lsu_d !== 8'd48) begin errors++; $display("FAIL lat_wr_issue got we=%b a=%0d d=%0d exp 1/30/48", ifb.lsu_we, ifb.lsu_a, ifb.lsu_d); end
        tick();
        checks++; if (ifb.m0_ack !== 1'b1 || ifb.lsu_we !== 1'b0) begin errors++; $display("FAIL lat_wr_ack got ack=%b we=%b exp 1/0", ifb.m0_ack, ifb.lsu_we); end
        ifb.m0_req = 1'b0;
        tick();
        ifb.m1_req = 1'b1; ifb.m1_we = 1'b0; ifb.m1_a = 16'd30; ifb.m1_d = 8'd0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (ifb.lsu_re !== 1'b1 || ifb.lsu_a !== 16'd30 || ifb.m1_ack !== 1'b0) begin errors++; $display("FAIL lat_rd_hold cycle %0d got re=%b a=%0d ack=%b exp 1/30/0", k, ifb.lsu_re, ifb.lsu_a, ifb.m1_ack); end
        end
        tick();
        checks++; if (ifb.m1_ack !== 1'b1 || ifb.m1_q !== 8'd48 || ifb.lsu_re !== 1'b0) begin errors++; $display("FAIL lat_rd_ack got ack=%b q=%0d re=%b exp 1/48/0", ifb.m1_ack, ifb.m1_q, ifb.lsu_re); end
        ifb.m1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        ifb.m1_req = 1'b1; ifb.m1_we = 1'b0; ifb.m1_a = 16'd30;
        tick();
        tick();
        checks++; if (ifb.busy !== 1'b1 || ifb.lsu_re !== 1'b1) begin errors++; $display("FAIL abort_wait got busy=%b re=%b exp 1/1", ifb.busy, ifb.lsu_re); end
        rst = 1'b0;
        tick();
        checks++; if ({ifb.lsu_re, ifb.lsu_we, ifb.m1_ack, ifb.m1_err, ifb.busy} !== 5'b0) begin errors++; $display("FAIL abort_ctl got %b exp 00000", {ifb.lsu_re, ifb.lsu_we, ifb.m1_ack, ifb.m1_err, ifb.busy}); end
        checks++; if (ifb.last_gnt !== 1'b1 || ifb.m1_q !== 8'd0 || ifb.lsu_a !== 16'd0) begin errors++; $display("FAIL abort_state got gnt=%b q=%0d a=%0d exp 1/0/0", ifb.last_gnt, ifb.m1_q, ifb.lsu_a); end
        rst = 1'b1;
        tick();
        checks++; if (ifb.lsu_re !== 1'b1 || ifb.last_gnt !== 1'b1 || ifb.lsu_a !== 16'd30) begin errors++; $display("FAIL abort_regrant got re=%b gnt=%b a=%0d exp 1/1/30", ifb.lsu_re, ifb.last_gnt, ifb.lsu_a); end
        for (int k = 2; k <= 3; k++) begin
            tick();
            checks++; if (ifb.m1_ack !== 1'b0) begin errors++; $display("FAIL abort_early_ack cycle %0d got %b exp 0", k, ifb.m1_ack); end
        end
        tick();
        checks++; if (ifb.m1_ack !== 1'b1 || ifb.m1_q !== 8'd48) begin errors++; $display("FAIL abort_rd_ack got ack=%b q=%0d exp 1/48", ifb.m1_ack, ifb.m1_q); end
        ifb.m1_req = 1'b0;
        tick();
    endtask

    initial begin
        ifa.m0_req = 1'b0; ifa.m0_we = 1'b0; ifa.m0_a = 16'd0; ifa.m0_d = 8'd0;
        ifa.m1_req = 1'b0; ifa.m1_we = 1'b0; ifa.m1_a = 16'd0; ifa.m1_d = 8'd0;
        ifb.m0_req = 1'b0; ifb.m0_we = 1'b0; ifb.m0_a = 16'd0; ifb.m0_d = 8'd0;
        ifb.m1_req = 1'b0; ifb.m1_we = 1'b0; ifb.m1_a = 16'd0; ifb.m1_d = 8'd0;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_rom();
        test_read_latency();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-port arbiter and sequencer in front of the single-ported load/store unit (`lsu`). It accepts byte read/write requests from two masters (port 0: instruction fetch, port 1: data/DMA), grants them round-robin, and drives the LSU `a`/`d`/`re`/`we` pins for exactly one transaction at a time. It returns read data with a one-cycle acknowledge per transaction. Writes that target the ROM window are suppressed and flagged.

## Interface
Parameters:
- `READ_LAT`, default 0: clock edges after the ISSUE cycle before `lsu_q` is valid. Legal range is 0–3; 0 means a combinational LSU read.
- `ROM_BASE`, default 16'h8000: writes to addresses ≥ ROM_BASE are not issued.

Ports (N = 0, 1):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled on the `clk` rising edge.
- `mN_req`  in  1  request; held high with fields stable until `mN_ack`.
- `mN_we`  in  1  1 = write, 0 = read.
- `mN_a`  in  16  byte address.
- `mN_d`  in  8  write data.
- `mN_ack`  out  1  one-cycle completion pulse.
- `mN_err`  out  1  pulses with `mN_ack` when a write was suppressed.
- `mN_q`  out  8  last read data for port N; held until that port's next read completes.
- `lsu_a`  out  16  LSU address.
- `lsu_d`  out  8  LSU write data.
- `lsu_re`  out  1  LSU read enable.
- `lsu_we`  out  1  LSU write enable.
- `lsu_q`  in  8  LSU read data.
- `busy`  out  1  high in every state except IDLE.
- `last_gnt`  out  1  index of the most recently granted port.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE
  - If no request is pending, remain in IDLE.
  - Otherwise select a winner:
    - If only one request is pending, grant it.
    - If both are pending, grant the port ≠ `last_gnt`.
  - On grant: latch `we`, `a` and `d` into internal registers, set `last_gnt` to the winner, and go to ISSUE.
  - After the grant, changes to the requester's fields are ignored.
- ISSUE (one cycle)
  - `lsu_a` and `lsu_d` are driven from the latched values.
  - Read: `lsu_re` = 1. If READ_LAT = 0, capture `lsu_q` at the edge ending ISSUE and go to DONE; otherwise go to WAIT.
  - Write with a < ROM_BASE: `lsu_we` = 1 for this single cycle, then go to DONE.
  - Write with a ≥ ROM_BASE: `lsu_we` stays 0, an internal err flag is set, then go to DONE.
- WAIT (reads only)
  - Lasts READ_LAT cycles, counted by a 2-bit down-counter.
  - `lsu_re` and `lsu_a` are held stable.
  - `lsu_q` is captured at the edge ending the last WAIT cycle; then go to DONE.
- DONE (one cycle)
  - `lsu_re` = `lsu_we` = 0.
  - The winner's `mN_ack` = 1, and `mN_err` = 1 if the err flag is set.
  - On a read, `mN_q` is updated to the captured byte; the other port's `mN_q` is unchanged.
  - Return to IDLE.
- Requester rule: a master samples `ack` at the edge ending DONE and must drop `req` at that same edge unless it wants another transaction. A `req` seen high in the following IDLE cycle is a new request.
- `lsu_re` and `lsu_we` are never high simultaneously. Both are low in IDLE and DONE.

## Timing
- Reset (`rst` = 0 at a rising edge) gives:
  - state = IDLE
  - `lsu_a`, `lsu_d`, `lsu_re`, `lsu_we` = 0
  - `mN_ack`, `mN_err`, `mN_q` = 0
  - `busy` = 0
  - `last_gnt` = 1, so port 0 wins the first contention.
- Reset during ISSUE, WAIT or DONE aborts the transaction: no ack is produced, and `lsu_we`/`lsu_re` are low after that edge. A write issued in an aborted ISSUE cycle is not retried.
- Latency, measured from the IDLE cycle in which `req` is sampled:
  - `lsu_*` active in cycle +1 (ISSUE).
  - `ack` in cycle +2 for writes and READ_LAT = 0 reads.
  - `ack` in cycle +2+READ_LAT for reads in general.
- Transaction period is 3+READ_LAT cycles (reads) or 3 cycles (writes), because IDLE is mandatory between transactions.
- With both masters requesting continuously, grants strictly alternate 0, 1, 0, 1, … No master waits more than one foreign transaction.
- The ROM check is an unsigned 16-bit compare against ROM_BASE; address 16'hFFFF is legal.

## Test plan
1. Release reset; m0 writes a=0, d=100 → in cycle +1, `lsu_we`=1, `lsu_a`=0, `lsu_d`=100 for exactly one cycle; `m0_ack`=1 in cycle +2, `m0_err`=0; `last_gnt`=0.
2. m1 reads a=0 (READ_LAT=0) → `lsu_re` high for one cycle; `m1_ack` in cycle +2 with `m1_q`=100; `m0_q` stays 0.
3. Right after reset, m0 and m1 both hold req with reads of a=0 → grant order is 0, 1, 0, 1 over 4 transactions; acks spaced 3 cycles apart; `busy` low only in the IDLE cycles.
4. m0 writes a=16'h8000, d=48 → `lsu_we` never asserts; `m0_ack`=`m0_err`=1 in cycle +2; a following read of a=16'h8000 issues normally with `lsu_re`=1.
5. Instance with READ_LAT=2: write a=30, d=48, then read a=30 with the bench LSU model delaying data by 2 edges → `lsu_re` held 3 cycles with `lsu_a`=30 stable; `ack` in cycle +4; `q`=48.
6. Drive `rst`=0 during WAIT of a READ_LAT=2 read → no ack; all outputs 0 and `last_gnt`=1 after the edge; after release, a new m1 request is granted normally.
